// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, imem req/ack, hold buffer, redirects; optional IF_PERF_CNT_EN counters
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        load_valid;
  logic        load_bubble;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, next-register and memory-request logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    pc_out_d     = pc_out_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    load_valid   = 1'b0;
    load_bubble  = 1'b0;
    imem_req_o   = 1'b0;
    imem_addr_o  = 32'h0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pc_d    = RESET_PC;
          state_d = FETCH;
        end
      end

      FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          valid_d     = 1'b0;
          inst_d      = 32'h0;
          load_bubble = 1'b1;
          if (!imem_ack_i) begin
            // Request still in flight: remember its address so it can be drained.
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_plus4;
          if (stall_i) begin
            buf_inst_d = imem_rdata_i;
            buf_pc_d   = pc_plus4;
            state_d    = FULL;
          end else begin
            inst_d     = imem_rdata_i;
            pc_out_d   = pc_plus4;
            valid_d    = 1'b1;
            load_valid = 1'b1;
          end
        end else if (!stall_i) begin
          valid_d     = 1'b0;
          inst_d      = 32'h0;
          load_bubble = 1'b1;
        end
      end

      FULL: begin
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          valid_d     = 1'b0;
          inst_d      = 32'h0;
          buf_inst_d  = 32'h0;
          buf_pc_d    = 32'h0;
          load_bubble = 1'b1;
          state_d     = FETCH;
        end else if (!stall_i) begin
          inst_d     = buf_inst_q;
          pc_out_d   = buf_pc_q;
          valid_d    = 1'b1;
          load_valid = 1'b1;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        // Keep presenting the abandoned request until memory acks it.
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        valid_d     = 1'b0;
        inst_d      = 32'h0;
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          load_bubble = 1'b1;
        end else begin
          load_bubble = !stall_i;
        end
        if (imem_ack_i) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_inst_q   <= 32'h0;
      buf_pc_q     <= 32'h0;
      pc_out_q     <= 32'h0;
      inst_q       <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      pc_out_q     <= pc_out_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
    end
  end

  assign pc_o    = pc_out_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Delivered-instruction and bubble counters, wrapping at 32 bits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (load_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (load_bubble) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_perf;

  assign unused_perf  = load_valid ^ load_bubble;
  assign fetch_cnt_o  = 32'h0;
  assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with a latency-configurable memory model
module tb_if_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   wcnt;

  if_fetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .valid_o      (valid_o),
    .fetch_cnt_o  (fetch_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0] ^ 16'h1234};
  endfunction

  // Memory model: acks after lat cycles of continuous request; reset drops the request
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wcnt <= 0;
    else if (imem_req_o && !imem_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign imem_ack_i   = imem_req_o && (wcnt >= lat - 1);
  assign imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.pc   = addr + 32'd4;
    e.inst = mem_word(addr);
    sbq.push_back(e);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_pc_o"}, pc_o, 32'h0);
    chk({name, "_inst_o"}, inst_o, 32'h0);
    chk({name, "_valid_o"}, {31'h0, valid_o}, 32'h0);
    chk({name, "_req"}, {31'h0, imem_req_o}, 32'h0);
    chk({name, "_addr"}, imem_addr_o, 32'h0);
    chk({name, "_fetch_cnt"}, fetch_cnt_o, 32'h0);
    chk({name, "_bubble_cnt"}, bubble_cnt_o, 32'h0);
  endtask

  task automatic do_reset(input string name);
    rst_i = 1'b0;
    #1;
    check_zero(name);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Monitor: after each edge where outputs could update, compare against the scoreboard
  initial begin
    logic st;
    exp_t e;
    forever begin
      @(posedge clk_i);
      st = stall_i;
      #1;
      if (!st) begin
        if (valid_o) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery actual pc_o=%h inst_o=%h expected none", pc_o, inst_o);
          end else begin
            e = sbq.pop_front();
            chk("mon_pc_o", pc_o, e.pc);
            chk("mon_inst_o", inst_o, e.inst);
          end
        end else begin
          chk("mon_bubble_inst", inst_o, 32'h0);
        end
      end
    end
  end

  // Watchdog bound on the whole run
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; lat = 1;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t1_req", {31'h0, imem_req_o}, 32'h1);
    chk("t1_addr", imem_addr_o, 32'h0);
    repeat (4) @(negedge clk_i);
    do_reset("t1_rst");

    // Two-cycle memory, then reset mid-request
    lat = 2;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (8) @(negedge clk_i);
`ifdef IF_PERF_CNT_EN
    chk("t2_fetch_cnt", fetch_cnt_o, 32'd4);
    chk("t2_bubble_cnt", bubble_cnt_o, 32'd4);
`else
    chk("t2_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("t2_bubble_cnt", bubble_cnt_o, 32'd0);
`endif
    chk("t2_midreq_req", {31'h0, imem_req_o}, 32'h1);
    chk("t2_midreq_addr", imem_addr_o, 32'h10);
    do_reset("t2_rst");
    repeat (3) begin
      @(negedge clk_i);
      chk("idle_req", {31'h0, imem_req_o}, 32'h0);
    end

    // Stall with buffered 0x1000
    lat = 1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h1000;
    @(negedge clk_i);
    redirect_i = 1'b0; stall_i = 1'b1;
    chk("t3_addr", imem_addr_o, 32'h1000);
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_full_req", {31'h0, imem_req_o}, 32'h0);
      chk("t3_frozen_valid", {31'h0, valid_o}, 32'h0);
    end
    push_exp(32'h1000);
    stall_i = 1'b0;
    @(negedge clk_i);
    chk("t3_release_req", {31'h0, imem_req_o}, 32'h1);
    chk("t3_release_addr", imem_addr_o, 32'h1004);
    stall_i = 1'b1;
    @(negedge clk_i);
    chk("t5_full_req", {31'h0, imem_req_o}, 32'h0);

    // Redirect + stall together while FULL
    redirect_i = 1'b1; redirect_pc_i = 32'h3000;
    @(negedge clk_i);
    chk("t5_valid", {31'h0, valid_o}, 32'h0);
    chk("t5_inst", inst_o, 32'h0);
    chk("t5_req", {31'h0, imem_req_o}, 32'h1);
    chk("t5_addr", imem_addr_o, 32'h3000);
    redirect_i = 1'b0; stall_i = 1'b0;
    push_exp(32'h3000);
    @(negedge clk_i);
    do_reset("t5_rst");

    // Redirect while a 3-cycle request to 0x40 is outstanding
    lat = 3;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    @(negedge clk_i);
    redirect_i = 1'b0;
    for (int i = 0; i < 8 && imem_addr_o !== 32'h40; i++) @(negedge clk_i);
    chk("t4_reach_40", imem_addr_o, 32'h40);
    redirect_i = 1'b1; redirect_pc_i = 32'h2000;
    @(negedge clk_i);
    redirect_i = 1'b0;
    chk("t4_drain_req", {31'h0, imem_req_o}, 32'h1);
    chk("t4_drain_addr", imem_addr_o, 32'h40);
    chk("t4_drain_valid", {31'h0, valid_o}, 32'h0);
    push_exp(32'h2000);
    for (int i = 0; i < 8 && imem_addr_o !== 32'h2000; i++) @(negedge clk_i);
    chk("t4_target_addr", imem_addr_o, 32'h2000);
    for (int i = 0; i < 8 && valid_o !== 1'b1; i++) @(negedge clk_i);
    chk("t4_target_valid", {31'h0, valid_o}, 32'h1);
    do_reset("t4_rst");

    // Restart from RESET_PC and PC wrap
    lat = 1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t6_restart_addr", imem_addr_o, 32'h0);
    push_exp(32'h0);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk_i);
    redirect_i = 1'b0;
    chk("t6_wrap_req_addr", imem_addr_o, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    @(negedge clk_i);
    chk("t6_wrapped_addr", imem_addr_o, 32'h0);
    @(negedge clk_i);
    do_reset("t6_rst");

    @(negedge clk_i);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register. Holds the program counter and issues requests to instruction memory over a req/ack handshake. Presents the fetched instruction, its PC+4, and a valid flag to IF/ID, inserting bubbles on memory wait. Honours hazard-unit stalls with a one-entry hold buffer and branch/jump redirects from ID.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset and on start
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  begin fetching from `RESET_PC`; sampled only in IDLE
- `stall_i`  in  1  hazard unit hold; 1 = outputs must not change
- `redirect_i`  in  1  branch/jump taken in ID
- `redirect_pc_i`  in  32  target address for redirect
- `imem_req_o`  out  1  memory request
- `imem_addr_o`  out  32  request address; stable while `imem_req_o`=1 and no ack
- `imem_ack_i`  in  1  memory response valid; may arrive in the same cycle as req
- `imem_rdata_i`  in  32  instruction word, valid when `imem_ack_i`=1
- `pc_o`  out  32  fetched address + 4, to IF/ID
- `inst_o`  out  32  fetched instruction, 0 (NOP) when not valid
- `valid_o`  out  1  `inst_o` holds a real instruction
- `fetch_cnt_o`  out  32  delivered-instruction count (see Configuration)
- `bubble_cnt_o`  out  32  bubble-cycle count (see Configuration)

## Operation
- States: IDLE, FETCH, FULL, DRAIN. Internal regs: `pc` (next fetch address), `buf_inst`/`buf_pc` (hold buffer).
- IDLE: `imem_req_o`=0. `start_i`=1 -> `pc`<=`RESET_PC`, go FETCH.
- FETCH: `imem_req_o`=1, `imem_addr_o`=`pc`.
  - Ack & !stall: `inst_o`<=rdata, `pc_o`<=`pc`+4, `valid_o`<=1, `pc`<=`pc`+4; stay FETCH.
  - Ack & stall: `buf_inst`<=rdata, `buf_pc`<=`pc`+4, `pc`<=`pc`+4, go FULL; outputs unchanged.
  - No ack & !stall: bubble; `valid_o`<=0, `inst_o`<=0, `pc_o` unchanged.
  - No ack & stall: outputs unchanged.
- FULL: `imem_req_o`=0. Stall drops -> outputs loaded from buffer, `valid_o`<=1, go FETCH.
- DRAIN: `imem_req_o`=1 with the pre-redirect address. On ack, data is discarded and state goes FETCH. Until then, outputs are held as a bubble.
- Redirect has top priority in every non-IDLE state, overriding stall. Effects:
  - `pc`<=`redirect_pc_i`; `valid_o`<=0; `inst_o`<=0; buffer dropped.
  - From FETCH without ack the request is outstanding -> DRAIN. From FETCH with ack, the data is dropped -> FETCH.
  - FULL -> FETCH. DRAIN -> stays DRAIN with the newer target.
- PC arithmetic is 32-bit, wrapping 32'hFFFF_FFFC + 4 -> 0. Low two bits are not checked.

## Timing
- Reset (async assert): state IDLE, `pc`=`RESET_PC`. All of the following are 0: `pc_o`, `inst_o`, `valid_o`, `imem_req_o`, `imem_addr_o`, buffer, counters. Reset deasserts synchronously to `clk_i` in the system.
- Reset mid-request abandons the outstanding request. The memory model must drop it.
- `start_i` sampled at edge N -> `imem_req_o` high after N. With a zero-wait ack, `valid_o`=1 after edge N+1.
- Zero-wait memory gives one instruction per cycle. A k-cycle memory gives k-1 bubble cycles per instruction.
- Redirect at edge M: the first target request is issued after M, or after the DRAIN ack. The target instruction is valid no earlier than edge M+1.
- Stall release: buffered instruction appears on the first edge with `stall_i`=0. The new request is issued in the following cycle.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `fetch_cnt_o` increments on every edge loading `valid_o`<=1.
  - `bubble_cnt_o` increments on every edge loading a bubble (not on stall cycles).
  - Both are 32-bit, wrap to 0, and reset to 0.
- Not defined: both ports tied to 0, no counter flops.

## Test plan
- Zero-wait memory, `RESET_PC`=0x0, start, 4 cycles -> `pc_o` 0x4,0x8,0xC,0x10 on consecutive edges, `valid_o`=1, `inst_o` equals the memory words.
- Memory with 2-cycle ack latency -> alternating valid/bubble. Bubble cycles show `inst_o`=0, `valid_o`=0; with `IF_PERF_CNT_EN`, after 4 instructions `fetch_cnt_o`=4, `bubble_cnt_o`=4.
- Ack of 0x1000 while `stall_i`=1 for 3 cycles -> outputs frozen, `imem_req_o`=0 during FULL. On release, `inst_o`=mem[0x1000], `pc_o`=0x1004, then a request for 0x1004.
- Redirect to 0x2000 while a 3-cycle request to 0x40 is outstanding -> DRAIN. The 0x40 data is never output; the next request address is 0x2000, and `valid_o`=1 with `pc_o`=0x2004.
- Redirect and stall in the same cycle while in FULL -> buffer dropped, `valid_o`=0, next request is `redirect_pc_i`.
- `rst_i` low mid-request -> all outputs 0 immediately (before next edge). After release, IDLE until `start_i`; fetch restarts at `RESET_PC`.
